// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//
// Data-memory controller between the processor DMEM port and a word-wide,
// variable-latency SRAM with a req/ack handshake. Byte, half-word and word
// loads/stores become word-addressed accesses with byte enables. Load data is
// pulled from the addressed lane and zero- or sign-extended. The processor is
// stalled until the access finishes. A watchdog aborts unacknowledged accesses.
//
// Bit numbering: the interface is described MSB-first (bit 0 = MSB, bit 31 =
// LSB). Buses here are declared [N-1:0], so description bit i is index N-1-i.
// The numeric values are identical. For example, description addr[30:31] is
// addr_from_proc[1:0] here. Description mem_be bit 0 (lane [0:7], the MSB byte)
// is mem_be[3] here. So a byte at lane 3 still reads as mem_be = 4'b0001.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles without ack before abort (0 = no watchdog),
//                   0..255, 8-bit counter.
//
// Optional feature (compile-time macro)
//   DMEM_MISALIGN_TRAP_EN  trap misaligned half/word accesses instead of
//                          silently aligning them; drives the misaligned pulse.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   req_from_proc           access request
//   addr_from_proc          byte address
//   data_from_proc          store data, right-justified
//   write_enable_from_proc  1 = store, 0 = load
//   byte_from_proc          byte access (wins over half_word_from_proc)
//   half_word_from_proc     half-word access
//   sign_extend_from_proc   sign-extend sub-word loads
//   data_to_proc            registered load result
//   stall_to_proc           processor must hold PC and request
//   done_to_proc            one-cycle completion pulse
//   bus_error               one-cycle pulse (with done) on watchdog abort
//   misaligned              one-cycle pulse (with done) on misaligned trap
//   mem_addr                word address (byte address >> 2)
//   mem_wdata               lane-replicated store data
//   mem_be                  byte enables
//   mem_we                  write strobe (only while mem_req)
//   mem_req                 SRAM request
//   mem_rdata, mem_ack      SRAM read data and completion
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_from_proc,
  input  logic [31:0] addr_from_proc,
  input  logic [31:0] data_from_proc,
  input  logic        write_enable_from_proc,
  input  logic        byte_from_proc,
  input  logic        half_word_from_proc,
  input  logic        sign_extend_from_proc,
  output logic [31:0] data_to_proc,
  output logic        stall_to_proc,
  output logic        done_to_proc,
  output logic        bus_error,
  output logic        misaligned,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic [29:0] addr_reg, addr_next;
  logic [1:0]  lane_reg, lane_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic        byte_reg, byte_next;
  logic        half_reg, half_next;
  logic        sext_reg, sext_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] dout_reg, dout_next;
  logic        berr_reg, berr_next;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        mis_reg, mis_next;
`endif

  // Request-side formatting of the incoming access.
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_misaligned;

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = data_from_proc;
    if (byte_from_proc) begin
      req_be    = 4'b1000 >> addr_from_proc[1:0];
      req_wdata = {4{data_from_proc[7:0]}};
    end else if (half_word_from_proc) begin
      req_be    = addr_from_proc[1] ? 4'b0011 : 4'b1100;
      req_wdata = {2{data_from_proc[15:0]}};
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misaligned = !byte_from_proc &&
                          (half_word_from_proc ? addr_from_proc[0]
                                               : (addr_from_proc[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  // Read data split into big-endian lanes: lane 0 is the most significant byte.
  logic [7:0] rdata_lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_lane[gi] = mem_rdata[31-8*gi -: 8];
    end
  endgenerate

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_fmt;

  always_comb begin
    byte_val = rdata_lane[lane_reg];
    half_val = lane_reg[1] ? {rdata_lane[2], rdata_lane[3]}
                           : {rdata_lane[0], rdata_lane[1]};
    if (byte_reg)
      load_fmt = {{24{sext_reg & byte_val[7]}}, byte_val};
    else if (half_reg)
      load_fmt = {{16{sext_reg & half_val[15]}}, half_val};
    else
      load_fmt = mem_rdata;
  end

  // Counter value including the current ACCESS cycle, saturating at 255.
  logic [7:0] cnt_inc;
  assign cnt_inc = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    lane_next     = lane_reg;
    be_next       = be_reg;
    wdata_next    = wdata_reg;
    we_next       = we_reg;
    byte_next     = byte_reg;
    half_next     = half_reg;
    sext_next     = sext_reg;
    cnt_next      = cnt_reg;
    dout_next     = dout_reg;
    berr_next     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_next      = 1'b0;
`endif
    stall_to_proc = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        stall_to_proc = req_from_proc;
        if (req_from_proc) begin
          addr_next  = addr_from_proc[31:2];
          lane_next  = addr_from_proc[1:0];
          be_next    = req_be;
          wdata_next = req_wdata;
          we_next    = write_enable_from_proc;
          byte_next  = byte_from_proc;
          half_next  = half_word_from_proc;
          sext_next  = sign_extend_from_proc;
          cnt_next   = 8'd0;
          if (req_misaligned) begin
            // Trapped access never reaches the SRAM.
            dout_next  = 32'd0;
            state_next = ST_DONE;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_next   = 1'b1;
`endif
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall_to_proc = 1'b1;
        if (mem_ack) begin
          dout_next  = we_reg ? 32'd0 : load_fmt;
          state_next = ST_DONE;
        end else if ((TIMEOUT_LIM != 8'd0) && (cnt_inc == TIMEOUT_LIM)) begin
          dout_next  = 32'd0;
          berr_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_DONE: begin
        // The request still held here belongs to the finished access.
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      lane_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      half_reg  <= 1'b0;
      sext_reg  <= 1'b0;
      cnt_reg   <= '0;
      dout_reg  <= '0;
      berr_reg  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      lane_reg  <= lane_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      byte_reg  <= byte_next;
      half_reg  <= half_next;
      sext_reg  <= sext_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      berr_reg  <= berr_next;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_reg   <= mis_next;
`endif
    end
  end

  assign mem_req      = (state_reg == ST_ACCESS);
  assign mem_we       = we_reg && (state_reg == ST_ACCESS);
  assign mem_addr     = addr_reg;
  assign mem_be       = be_reg;
  assign mem_wdata    = wdata_reg;
  assign data_to_proc = dout_reg;
  assign done_to_proc = (state_reg == ST_DONE);
  assign bus_error    = berr_reg;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned   = mis_reg;
`else
  assign misaligned   = 1'b0;
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the processor's DMEM port and a word-wide, variable-latency SRAM with request/acknowledge handshake. It converts byte, half-word and word loads and stores into word-addressed accesses with byte enables. Load data is extracted from the addressed lane and zero- or sign-extended. The processor is stalled until the access completes, and a watchdog terminates accesses that are never acknowledged.

## Interface
- TIMEOUT_CYCLES, 255: cycles in ACCESS without ack before abort; 0 disables the watchdog. Range 0..255; counter is 8 bits.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_from_proc  in  1  access requested this cycle
- addr_from_proc  in  [0:31]  byte address; bit 31 is LSB
- data_from_proc  in  [0:31]  store data, right-justified
- write_enable_from_proc  in  1  1 = store, 0 = load
- byte_from_proc  in  1  byte access (wins over half_word)
- half_word_from_proc  in  1  half-word access
- sign_extend_from_proc  in  1  sign-extend sub-word loads
- data_to_proc  out  [0:31]  registered load result
- stall_to_proc  out  1  processor must hold PC and request
- done_to_proc  out  1  one-cycle completion pulse
- bus_error  out  1  one-cycle pulse on watchdog abort
- misaligned  out  1  one-cycle pulse; only with DMEM_MISALIGN_TRAP_EN, otherwise tied 0
- mem_addr  out  [0:29]  word address, equal to addr[0:29]
- mem_wdata  out  [0:31]  lane-replicated store data
- mem_be  out  [0:3]  byte enables; bit 0 = lane [0:7]
- mem_we  out  1  write strobe
- mem_req  out  1  SRAM request
- mem_rdata  in  [0:31]  SRAM read data
- mem_ack  in  1  SRAM completion, valid only while mem_req=1

## Operation
- Big-endian lanes: addr[30:31]=0 selects bits [0:7], and 3 selects bits [24:31].
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on req_from_proc, latch addr, data, control and the computed mem_be/mem_wdata, clear the timeout counter, then go to ACCESS.
  - ACCESS: hold mem_req=1 with mem_addr/mem_we/mem_be/mem_wdata stable.
    - On mem_ack: latch the formatted load result (0 for stores) into data_to_proc and go to DONE.
    - On counter == TIMEOUT_CYCLES (nonzero) with no ack: set data_to_proc = 0, go to DONE, and pulse bus_error.
  - DONE: done_to_proc=1, then go to IDLE unconditionally. The request still present in this cycle belongs to the finished access and is not re-issued.
- stall_to_proc = (IDLE & req_from_proc) | ACCESS; it is combinational and is 0 in DONE.
- Byte enables:
  - byte: one-hot at lane addr[30:31].
  - half: 1100 when addr[30]=0, 0011 when addr[30]=1.
  - word: 1111.
- Store data replication:
  - byte: data[24:31] copied to all 4 lanes.
  - half: data[16:31] copied twice.
  - word: data passed through unchanged.
- Load formatting: the selected lane goes to the low bits ([24:31] for byte, [16:31] for half). Upper bits are filled with the lane MSB if sign_extend_from_proc=1, else 0. Word loads pass through unchanged.
- mem_ack outside ACCESS is ignored.
- Reset values: IDLE, data_to_proc=0, and every other output 0.
- Reset mid-access: mem_req drops on the next edge and the pending access is abandoned; no done pulse is generated.

## Timing
- Request seen in cycle 0 → mem_req asserted in cycle 1 (registered).
- Ack in cycle N≥1 → data_to_proc valid and done_to_proc=1 in cycle N+1, with stall_to_proc=0 in that cycle.
- Minimum access is 3 cycles including DONE. The processor advances at the end of DONE.
- Back-to-back: a new request can be accepted in the IDLE cycle following DONE.
- Watchdog: abort occurs after TIMEOUT_CYCLES cycles in ACCESS, so DONE is at cycle TIMEOUT_CYCLES+1 after issue.
- The counter saturates and does not wrap.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are a word with addr[30:31]≠0 or a half with addr[31]=1.
  - They never assert mem_req. The FSM goes IDLE→DONE directly with data_to_proc=0, misaligned=1 and done_to_proc=1.
  - Misaligned stores are suppressed.
- Undefined: misalignment is not checked. Word accesses ignore addr[30:31] and half accesses ignore addr[31]; misaligned is tied to 0.

## Test plan
- Byte load, addr 0x103, sign_ext=1, SRAM returns 0x112233F4 with ack in cycle 2 → mem_be=0001, data_to_proc=0xFFFFFFF4, done pulse in cycle 3, stall high in cycles 0–2.
- Half store, addr 0x202, data 0x0000BEEF → mem_be=0011, mem_wdata=0xBEEFBEEF, mem_we=1, mem_addr=0x80.
- Word load with ack held low, TIMEOUT_CYCLES=4 → bus_error and done in cycle 5, data_to_proc=0, mem_req low from cycle 5.
- Reset asserted in the second ACCESS cycle, then ack → mem_req=0 after the edge, no done pulse, state IDLE, late ack ignored.
- Two back-to-back word loads, addrs 0x10 then 0x14 → exactly two mem_req sessions, no duplicate issue during DONE.
- With DMEM_MISALIGN_TRAP_EN, word store to 0x21 → misaligned and done in cycle 1, mem_req never asserted.
